usb_multi_ep_protocol_ctrl: RTL and testbench
=============================================

// Module: usb_multi_ep_protocol_ctrl
// PURPOSE
//  USB bulk protocol controller for NUM_EP endpoints sharing one data buffer. Sits between
//  the RX/TX packet codecs and the AHB-Lite buffer. It decodes IN/OUT token and data-PID
//  sequences, keeps a DATA0/DATA1 toggle per endpoint, times out when the host goes silent,
//  and answers with ACK/NAK/STALL or data.
// PARAMETERS
//  NUM_EP       2    number of bulk endpoints (1..16)
//  EP_W         $clog2(NUM_EP) (min 1)   endpoint index width
//  BUF_DEPTH    64   buffer bytes; OCC_W = $clog2(BUF_DEPTH+1)
//  TIMEOUT_CYC  256  cycles to wait for host data/ACK before abort; TO_W = $clog2(TIMEOUT_CYC+1)
// PORTS
//  clk                  in   1       system clock, single domain
//  n_rst                in   1       asynchronous active-low reset
//  RX_Packet_Valid      in   1       1-cycle strobe: RX_Packet/RX_Endpoint valid
//  RX_Packet            in   3       000 none,001 IN,010 OUT,011 ACK,100 DATA0,101 DATA1,111 corrupt
//  RX_Endpoint          in   EP_W    endpoint of token (ignored for non-token PIDs)
//  Buffer_Occupancy     in   OCC_W   bytes in buffer
//  TX_Packet_Data_Size  in   OCC_W   bytes firmware wants sent on next IN
//  Buffer_Reserved      in   1       AHB side owns buffer
//  EP_Enable            in   NUM_EP  endpoint enabled; 0 -> STALL
//  Toggle_Clear         in   NUM_EP  sync clear of per-EP toggle to DATA0
//  TX_Done              in   1       TX encoder finished current packet (1-cycle)
//  TX_Packet            out  3       000 none,001 DATA0,010 DATA1,011 ACK,100 NAK,101 STALL
//  Active_EP            out  EP_W    endpoint of current transaction
//  Toggle               out  NUM_EP  per-EP expected/next data toggle (0=DATA0)
//  RX_Transfer_Active, TX_Transfer_Active, D_Mode (1=host->EP), clear, out 1 each
//  RX_Data_Ready, RX_Error, TX_Error   out  1   registered 1-cycle pulses
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, TX_Packet=000, Toggle=0, timeout counter 0.
//  Outputs are decoded from the registered state (plus registered pulses). They change on
//   the clk edge that samples RX_Packet_Valid/TX_Done, so they are valid 1 cycle later.
//  States: IDLE, OUT_DATA, OUT_DISCARD, OUT_HS, IN_DATA, IN_WAIT_ACK, IN_HS.
//  IDLE, valid OUT to ep e:
//   e>=NUM_EP -> ignored, stay IDLE.
//   !EP_Enable[e] -> OUT_DISCARD (hs=STALL).
//   Occupancy!=0 or Buffer_Reserved -> OUT_DISCARD (hs=NAK).
//   else -> OUT_DATA. Active_EP<=e in all accepted cases.
//  OUT_DATA: D_Mode=1, RX_Transfer_Active=1. On DATA PID:
//   PID==Toggle[e] -> OUT_HS with ACK, flip Toggle[e], mark fresh.
//   PID!=Toggle[e] -> duplicate: OUT_HS with ACK, clear=1 for 1 cycle, no flip.
//   corrupt, any token, or timeout -> IDLE: RX_Error pulse, clear pulse, no handshake.
//    The aborting token is dropped.
//  OUT_DISCARD: D_Mode=1, RX_Transfer_Active=1, clear=1.
//   Any DATA PID -> OUT_HS with stored hs; RX_Error pulses on NAK/STALL entry.
//   Timeout -> IDLE.
//  OUT_HS: TX_Packet=hs, held until TX_Done -> IDLE.
//   RX_Data_Ready pulses on that TX_Done only if the ACK was fresh.
//  IDLE, valid IN to ep e:
//   disabled -> IN_HS STALL.
//   Buffer_Reserved or Occupancy<TX_Packet_Data_Size -> IN_HS NAK, TX_Error pulse, clear=1.
//   else -> IN_DATA. Size 0 with Occupancy 0 sends a zero-length packet.
//  IN_DATA: D_Mode=0, TX_Transfer_Active=1, TX_Packet=DATA0/1 per Toggle[e];
//   TX_Done -> IN_WAIT_ACK.
//  IN_WAIT_ACK: ACK -> flip Toggle[e], IDLE.
//   Other PID or timeout -> IDLE, TX_Error pulse, no flip (host retries same toggle).
//  IN_HS: TX_Packet=NAK/STALL until TX_Done -> IDLE.
//  Timeout counter: runs only in OUT_DATA/OUT_DISCARD/IN_WAIT_ACK, zeroed on state entry;
//   abort when count==TIMEOUT_CYC-1.
//  Toggle_Clear[e] has priority over a same-cycle flip of e.
//  Tokens in OUT_HS/IN_DATA/IN_HS are ignored.
//  n_rst mid-transaction returns to IDLE immediately and clears all toggles.
// TESTING
//  OUT ep1, Occ=0 -> D_Mode=1; DATA0 -> TX_Packet=011; TX_Done -> RX_Data_Ready pulse, Toggle[1]=1.
//  Repeat DATA0 to ep1 -> ACK, clear pulse, no RX_Data_Ready, Toggle[1] stays 1.
//  IN ep0, Occ=64, Size=64 -> TX_Packet=001; TX_Done, ACK -> Toggle[0]=1; then Toggle_Clear[0] -> 0.
//  IN ep0, Buffer_Reserved=1 -> TX_Packet=100, TX_Error pulse, clear=1; EP_Enable[0]=0 -> 101.
//  OUT ep0 then silence 256 cycles -> IDLE, RX_Error pulse; IN sent with no ACK -> TX_Error, toggle held.
//  Corrupt PID in OUT_DATA -> no handshake, RX_Error; reset mid IN_WAIT_ACK -> all outputs 0.

Source files
------------

// File: rtl/usb_multi_ep_protocol_ctrl.sv
// USB bulk protocol controller: token/data-PID sequencing, per-EP DATA0/1 toggles, host-silence timeout.
// Latency: outputs follow the clk edge that samples RX_Packet_Valid/TX_Done (valid one cycle later).
// Backpressure: handshake/data PIDs are held on TX_Packet until TX_Done; tokens arriving mid-transaction are dropped.
module usb_multi_ep_protocol_ctrl #(
  parameter int NUM_EP      = 2,
  parameter int EP_W        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  parameter int BUF_DEPTH   = 64,
  parameter int OCC_W       = $clog2(BUF_DEPTH + 1),
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              RX_Packet_Valid,
  input  logic [2:0]        RX_Packet,
  input  logic [EP_W-1:0]   RX_Endpoint,
  input  logic [OCC_W-1:0]  Buffer_Occupancy,
  input  logic [OCC_W-1:0]  TX_Packet_Data_Size,
  input  logic              Buffer_Reserved,
  input  logic [NUM_EP-1:0] EP_Enable,
  input  logic [NUM_EP-1:0] Toggle_Clear,
  input  logic              TX_Done,
  output logic [2:0]        TX_Packet,
  output logic [EP_W-1:0]   Active_EP,
  output logic [NUM_EP-1:0] Toggle,
  output logic              RX_Transfer_Active,
  output logic              TX_Transfer_Active,
  output logic              D_Mode,
  output logic              clear,
  output logic              RX_Data_Ready,
  output logic              RX_Error,
  output logic              TX_Error
);

  localparam logic [2:0] PID_IN = 3'b001, PID_OUT = 3'b010, PID_ACK = 3'b011;
  localparam logic [2:0] PID_DATA0 = 3'b100, PID_DATA1 = 3'b101, PID_BAD = 3'b111;
  localparam logic [2:0] TX_NONE = 3'b000, TX_DATA0 = 3'b001, TX_DATA1 = 3'b010;
  localparam logic [2:0] TX_ACK = 3'b011, TX_NAK = 3'b100, TX_STALL = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_OUT_DATA, S_OUT_DISCARD, S_OUT_HS, S_IN_DATA, S_IN_WAIT_ACK, S_IN_HS
  } state_t;

  state_t            state, state_n;
  logic [EP_W-1:0]   active_ep, ep_n;
  logic [2:0]        hs, hs_n;
  logic              fresh, fresh_n;
  logic [NUM_EP-1:0] toggle;
  logic [TO_W-1:0]   to_cnt;
  logic              rdr_q, rxe_q, txe_q, clr_q;
  logic              rdr_n, rxe_n, txe_n, clr_n, flip;
  logic              ep_ok, data_pid, timeout, counting;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode plus the side effects (handshake choice, pulses, toggle flip) of each transition.
  always_comb begin
    state_n  = state;
    ep_n     = active_ep;
    hs_n     = hs;
    fresh_n  = fresh;
    rdr_n    = 1'b0;
    rxe_n    = 1'b0;
    txe_n    = 1'b0;
    clr_n    = 1'b0;
    flip     = 1'b0;
    ep_ok    = int'(RX_Endpoint) < NUM_EP;
    data_pid = (RX_Packet == PID_DATA0) || (RX_Packet == PID_DATA1);
    counting = (state == S_OUT_DATA) || (state == S_OUT_DISCARD) || (state == S_IN_WAIT_ACK);
    timeout  = counting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    case (state)
      S_IDLE: begin
        if (RX_Packet_Valid && ep_ok && RX_Packet == PID_OUT) begin
          ep_n    = RX_Endpoint;
          fresh_n = 1'b0;
          if (!EP_Enable[RX_Endpoint]) begin
            state_n = S_OUT_DISCARD;
            hs_n    = TX_STALL;
          end else if (Buffer_Occupancy != '0 || Buffer_Reserved) begin
            state_n = S_OUT_DISCARD;
            hs_n    = TX_NAK;
          end else begin
            state_n = S_OUT_DATA;
          end
        end else if (RX_Packet_Valid && ep_ok && RX_Packet == PID_IN) begin
          ep_n = RX_Endpoint;
          if (!EP_Enable[RX_Endpoint]) begin
            state_n = S_IN_HS;
            hs_n    = TX_STALL;
          end else if (Buffer_Reserved || Buffer_Occupancy < TX_Packet_Data_Size) begin
            state_n = S_IN_HS;
            hs_n    = TX_NAK;
            txe_n   = 1'b1;
          end else begin
            state_n = S_IN_DATA;
          end
        end
      end
      S_OUT_DATA: begin
        if (RX_Packet_Valid && data_pid) begin
          state_n = S_OUT_HS;
          hs_n    = TX_ACK;
          // A DATA PID that misses the expected toggle is a retry of data already taken.
          if (RX_Packet[0] == toggle[active_ep]) begin
            flip    = 1'b1;
            fresh_n = 1'b1;
          end else begin
            clr_n = 1'b1;
          end
        end else if ((RX_Packet_Valid && (RX_Packet == PID_BAD || RX_Packet == PID_IN ||
                      RX_Packet == PID_OUT)) || timeout) begin
          state_n = S_IDLE;
          rxe_n   = 1'b1;
          clr_n   = 1'b1;
        end
      end
      S_OUT_DISCARD: begin
        if (RX_Packet_Valid && data_pid) begin
          state_n = S_OUT_HS;
          rxe_n   = 1'b1;
        end else if (timeout) begin
          state_n = S_IDLE;
        end
      end
      S_OUT_HS: begin
        if (TX_Done) begin
          state_n = S_IDLE;
          rdr_n   = fresh;
        end
      end
      S_IN_DATA: begin
        if (TX_Done) state_n = S_IN_WAIT_ACK;
      end
      S_IN_WAIT_ACK: begin
        if (RX_Packet_Valid && RX_Packet == PID_ACK) begin
          state_n = S_IDLE;
          flip    = 1'b1;
        end else if (RX_Packet_Valid || timeout) begin
          state_n = S_IDLE;
          txe_n   = 1'b1;
        end
      end
      S_IN_HS: begin
        if (TX_Done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Transaction context, one-cycle pulses and the host-silence counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active_ep <= '0;
      hs        <= TX_NONE;
      fresh     <= 1'b0;
      rdr_q     <= 1'b0;
      rxe_q     <= 1'b0;
      txe_q     <= 1'b0;
      clr_q     <= 1'b0;
      to_cnt    <= '0;
    end else begin
      active_ep <= ep_n;
      hs        <= hs_n;
      fresh     <= fresh_n;
      rdr_q     <= rdr_n;
      rxe_q     <= rxe_n;
      txe_q     <= txe_n;
      clr_q     <= clr_n;
      if (state_n != state || !counting) to_cnt <= '0;
      else                               to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Per-endpoint data toggles; a firmware clear beats a same-cycle flip.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      toggle <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (Toggle_Clear[i])                         toggle[i] <= 1'b0;
        else if (flip && active_ep == EP_W'(i))      toggle[i] <= ~toggle[i];
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    TX_Packet          = TX_NONE;
    D_Mode             = 1'b0;
    RX_Transfer_Active = 1'b0;
    TX_Transfer_Active = 1'b0;
    clear              = clr_q;
    case (state)
      S_OUT_DATA: begin
        D_Mode             = 1'b1;
        RX_Transfer_Active = 1'b1;
      end
      S_OUT_DISCARD: begin
        D_Mode             = 1'b1;
        RX_Transfer_Active = 1'b1;
        clear              = 1'b1;
      end
      S_OUT_HS: TX_Packet = hs;
      S_IN_DATA: begin
        TX_Transfer_Active = 1'b1;
        TX_Packet          = toggle[active_ep] ? TX_DATA1 : TX_DATA0;
      end
      S_IN_HS: begin
        TX_Packet = hs;
        clear     = clr_q | (hs == TX_NAK);
      end
      default: ;
    endcase
  end

  assign Active_EP     = active_ep;
  assign Toggle        = toggle;
  assign RX_Data_Ready = rdr_q;
  assign RX_Error      = rxe_q;
  assign TX_Error      = txe_q;

endmodule

// File: tb/tb_usb_multi_ep_protocol_ctrl.sv
// Bench for usb_multi_ep_protocol_ctrl: directed scenarios plus randomized IN/OUT transactions
// checked against a transaction-level model of the per-endpoint toggles and handshake rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_usb_multi_ep_protocol_ctrl;
  localparam int NUM_EP = 2;
  localparam int EP_W = 1;
  localparam int OCC_W = 7;
  localparam int TIMEOUT = 256;
  localparam logic [2:0] P_IN = 3'b001, P_OUT = 3'b010, P_ACK = 3'b011;
  localparam logic [2:0] P_D0 = 3'b100, P_D1 = 3'b101, P_BAD = 3'b111;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              RX_Packet_Valid = 1'b0;
  logic [2:0]        RX_Packet = '0;
  logic [EP_W-1:0]   RX_Endpoint = '0;
  logic [OCC_W-1:0]  Buffer_Occupancy = '0;
  logic [OCC_W-1:0]  TX_Packet_Data_Size = '0;
  logic              Buffer_Reserved = 1'b0;
  logic [NUM_EP-1:0] EP_Enable = '0;
  logic [NUM_EP-1:0] Toggle_Clear = '0;
  logic              TX_Done = 1'b0;
  logic [2:0]        TX_Packet;
  logic [EP_W-1:0]   Active_EP;
  logic [NUM_EP-1:0] Toggle;
  logic              RX_Transfer_Active, TX_Transfer_Active, D_Mode, clear;
  logic              RX_Data_Ready, RX_Error, TX_Error;

  int n_checks = 0;
  int n_fail = 0;
  logic [NUM_EP-1:0] model_tog = '0;

  usb_multi_ep_protocol_ctrl #(.NUM_EP(NUM_EP), .BUF_DEPTH(64), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .RX_Packet_Valid(RX_Packet_Valid), .RX_Packet(RX_Packet),
    .RX_Endpoint(RX_Endpoint), .Buffer_Occupancy(Buffer_Occupancy),
    .TX_Packet_Data_Size(TX_Packet_Data_Size), .Buffer_Reserved(Buffer_Reserved),
    .EP_Enable(EP_Enable), .Toggle_Clear(Toggle_Clear), .TX_Done(TX_Done),
    .TX_Packet(TX_Packet), .Active_EP(Active_EP), .Toggle(Toggle),
    .RX_Transfer_Active(RX_Transfer_Active), .TX_Transfer_Active(TX_Transfer_Active),
    .D_Mode(D_Mode), .clear(clear), .RX_Data_Ready(RX_Data_Ready), .RX_Error(RX_Error),
    .TX_Error(TX_Error));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle packet strobe; returns on the falling edge after the sampling edge.
  task automatic send(input logic [2:0] pid, input logic [EP_W-1:0] ep);
    RX_Packet_Valid = 1'b1; RX_Packet = pid; RX_Endpoint = ep;
    @(negedge clk);
    RX_Packet_Valid = 1'b0; RX_Packet = '0;
  endtask

  task automatic tx_done();
    TX_Done = 1'b1;
    @(negedge clk);
    TX_Done = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(2);
    n_checks++; if (TX_Packet !== 3'b000) begin n_fail++; $display("FAIL reset_tx_packet: got %b want 000", TX_Packet); end
    n_checks++; if (Toggle !== '0) begin n_fail++; $display("FAIL reset_toggle: got %b want 00", Toggle); end
    n_checks++; if ({Active_EP, RX_Transfer_Active, TX_Transfer_Active, D_Mode, clear, RX_Data_Ready, RX_Error, TX_Error} !== '0) begin
      n_fail++; $display("FAIL reset_flags: got %b want all zero", {Active_EP, RX_Transfer_Active, TX_Transfer_Active, D_Mode, clear, RX_Data_Ready, RX_Error, TX_Error}); end
    n_rst = 1'b1;
    model_tog = '0;
    tick(1);
  endtask

  task automatic test_out_fresh_and_dup();
    EP_Enable = 2'b11; Buffer_Occupancy = '0; Buffer_Reserved = 1'b0;
    send(P_OUT, 1);
    n_checks++; if (D_Mode !== 1'b1) begin n_fail++; $display("FAIL out_dmode: got %b want 1", D_Mode); end
    n_checks++; if (Active_EP !== 1'b1) begin n_fail++; $display("FAIL out_active_ep: got %0d want 1", Active_EP); end
    send(P_D0, 0);
    n_checks++; if (TX_Packet !== 3'b011) begin n_fail++; $display("FAIL out_ack: got %b want 011", TX_Packet); end
    tx_done();
    model_tog[1] = 1'b1;
    n_checks++; if (RX_Data_Ready !== 1'b1) begin n_fail++; $display("FAIL out_rdr: got %b want 1", RX_Data_Ready); end
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL out_toggle: got %b want %b", Toggle, model_tog); end
    send(P_OUT, 1);
    send(P_D0, 0);
    n_checks++; if ({TX_Packet, clear} !== 4'b0111) begin n_fail++; $display("FAIL dup_ack_clear: got %b want 0111", {TX_Packet, clear}); end
    tx_done();
    n_checks++; if (RX_Data_Ready !== 1'b0) begin n_fail++; $display("FAIL dup_rdr: got %b want 0", RX_Data_Ready); end
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL dup_toggle: got %b want %b", Toggle, model_tog); end
  endtask

  task automatic test_in_paths();
    EP_Enable = 2'b11; Buffer_Occupancy = 7'd64; TX_Packet_Data_Size = 7'd64; Buffer_Reserved = 1'b0;
    send(P_IN, 0);
    n_checks++; if ({TX_Packet, TX_Transfer_Active} !== 4'b0011) begin n_fail++; $display("FAIL in_data0: got %b want 0011", {TX_Packet, TX_Transfer_Active}); end
    tx_done();
    send(P_ACK, 0);
    model_tog[0] = 1'b1;
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL in_ack_toggle: got %b want %b", Toggle, model_tog); end
    Toggle_Clear = 2'b01; tick(1); Toggle_Clear = '0;
    model_tog[0] = 1'b0;
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL toggle_clear: got %b want %b", Toggle, model_tog); end
    // Firmware clear in the same cycle as the ACK-driven flip must win.
    send(P_IN, 0);
    tx_done();
    Toggle_Clear = 2'b01;
    send(P_ACK, 0);
    Toggle_Clear = '0;
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL clear_priority: got %b want %b", Toggle, model_tog); end
    Buffer_Reserved = 1'b1;
    send(P_IN, 0);
    n_checks++; if ({TX_Packet, TX_Error, clear} !== 5'b10011) begin n_fail++; $display("FAIL in_nak: got %b want 10011", {TX_Packet, TX_Error, clear}); end
    tx_done();
    Buffer_Reserved = 1'b0; EP_Enable = 2'b10;
    send(P_IN, 0);
    n_checks++; if ({TX_Packet, TX_Error} !== 4'b1010) begin n_fail++; $display("FAIL in_stall: got %b want 1010", {TX_Packet, TX_Error}); end
    tx_done();
    n_checks++; if (TX_Packet !== 3'b000) begin n_fail++; $display("FAIL in_stall_done: got %b want 000", TX_Packet); end
  endtask

  task automatic test_timeout();
    EP_Enable = 2'b11; Buffer_Occupancy = '0; Buffer_Reserved = 1'b0;
    send(P_OUT, 0);
    tick(TIMEOUT - 1);
    n_checks++; if (D_Mode !== 1'b1) begin n_fail++; $display("FAIL out_before_timeout: got %b want 1", D_Mode); end
    tick(1);
    n_checks++; if ({D_Mode, RX_Error, clear} !== 3'b011) begin n_fail++; $display("FAIL out_timeout: got %b want 011", {D_Mode, RX_Error, clear}); end
    tick(1);
    n_checks++; if (RX_Error !== 1'b0) begin n_fail++; $display("FAIL rx_error_width: got %b want 0", RX_Error); end
    Buffer_Occupancy = 7'd10; TX_Packet_Data_Size = 7'd10;
    send(P_IN, 1);
    tx_done();
    tick(TIMEOUT - 1);
    n_checks++; if (TX_Error !== 1'b0) begin n_fail++; $display("FAIL in_before_timeout: got %b want 0", TX_Error); end
    tick(1);
    n_checks++; if (TX_Error !== 1'b1) begin n_fail++; $display("FAIL in_timeout: got %b want 1", TX_Error); end
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL in_timeout_toggle: got %b want %b", Toggle, model_tog); end
  endtask

  task automatic test_corrupt();
    EP_Enable = 2'b11; Buffer_Occupancy = '0; Buffer_Reserved = 1'b0;
    send(P_OUT, 1);
    send(P_BAD, 0);
    n_checks++; if ({TX_Packet, D_Mode, RX_Error, clear} !== 6'b000011) begin
      n_fail++; $display("FAIL corrupt_abort: got %b want 000011", {TX_Packet, D_Mode, RX_Error, clear}); end
    tick(1);
    n_checks++; if (Toggle !== model_tog) begin n_fail++; $display("FAIL corrupt_toggle: got %b want %b", Toggle, model_tog); end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [EP_W-1:0] ep;
      logic en, res;
      logic [2:0] exp_pkt;
      ep = EP_W'($urandom_range(0, NUM_EP - 1));
      en = $urandom_range(0, 3) != 0;
      res = $urandom_range(0, 3) == 0;
      EP_Enable = NUM_EP'($urandom); EP_Enable[ep] = en;
      Buffer_Reserved = res;
      if ($urandom_range(0, 7) == 0) begin
        Toggle_Clear = NUM_EP'($urandom); tick(1);
        model_tog = model_tog & ~Toggle_Clear; Toggle_Clear = '0;
      end
      if ($urandom_range(0, 1) == 0) begin
        logic pid_t, disc, fresh;
        Buffer_Occupancy = ($urandom_range(0, 1) == 0) ? 7'd0 : OCC_W'($urandom_range(1, 64));
        pid_t = 1'($urandom_range(0, 1));
        exp_pkt = !en ? 3'b101 : (Buffer_Occupancy != 0 || res) ? 3'b100 : 3'b011;
        disc = exp_pkt != 3'b011;
        fresh = !disc && (pid_t == model_tog[ep]);
        send(P_OUT, ep);
        n_checks++; if ({D_Mode, clear} !== {1'b1, disc}) begin n_fail++; $display("FAIL rnd_out_token it%0d: got %b want %b", it, {D_Mode, clear}, {1'b1, disc}); end
        send(pid_t ? P_D1 : P_D0, ep);
        n_checks++; if ({TX_Packet, RX_Error, clear} !== {exp_pkt, disc, !disc && !fresh}) begin
          n_fail++; $display("FAIL rnd_out_hs it%0d: got %b want %b", it, {TX_Packet, RX_Error, clear}, {exp_pkt, disc, !disc && !fresh}); end
        tx_done();
        if (fresh) model_tog[ep] = ~model_tog[ep];
        n_checks++; if ({RX_Data_Ready, Toggle} !== {fresh, model_tog}) begin
          n_fail++; $display("FAIL rnd_out_done it%0d: got %b want %b", it, {RX_Data_Ready, Toggle}, {fresh, model_tog}); end
      end else begin
        int sz, occ;
        logic nak;
        sz = $urandom_range(0, 64);
        case ($urandom_range(0, 3))
          0: occ = sz;
          1: occ = (sz > 0) ? sz - 1 : 0;
          2: occ = 64;
          default: occ = 0;
        endcase
        TX_Packet_Data_Size = OCC_W'(sz); Buffer_Occupancy = OCC_W'(occ);
        nak = en && (res || occ < sz);
        exp_pkt = !en ? 3'b101 : nak ? 3'b100 : (model_tog[ep] ? 3'b010 : 3'b001);
        send(P_IN, ep);
        n_checks++; if ({TX_Packet, TX_Error, TX_Transfer_Active} !== {exp_pkt, nak, en && !nak}) begin
          n_fail++; $display("FAIL rnd_in_token it%0d: got %b want %b", it, {TX_Packet, TX_Error, TX_Transfer_Active}, {exp_pkt, nak, en && !nak}); end
        tx_done();
        if (en && !nak) begin
          logic ack;
          ack = $urandom_range(0, 2) != 0;
          send(ack ? P_ACK : P_D0, ep);
          if (ack) model_tog[ep] = ~model_tog[ep];
          n_checks++; if ({TX_Error, Toggle} !== {!ack, model_tog}) begin
            n_fail++; $display("FAIL rnd_in_ack it%0d: got %b want %b", it, {TX_Error, Toggle}, {!ack, model_tog}); end
        end else begin
          n_checks++; if (TX_Packet !== 3'b000) begin n_fail++; $display("FAIL rnd_in_hs_done it%0d: got %b want 000", it, TX_Packet); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_transaction();
    EP_Enable = 2'b11; Buffer_Occupancy = '0; Buffer_Reserved = 1'b0;
    Toggle_Clear = 2'b11; tick(1); Toggle_Clear = '0; model_tog = '0;
    send(P_OUT, 1);
    send(P_D0, 1);
    tx_done();
    Buffer_Occupancy = 7'd5; TX_Packet_Data_Size = 7'd5;
    send(P_IN, 1);
    n_checks++; if (TX_Packet !== 3'b010) begin n_fail++; $display("FAIL pre_reset_data1: got %b want 010", TX_Packet); end
    tx_done();
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if ({TX_Packet, Active_EP, Toggle, RX_Transfer_Active, TX_Transfer_Active, D_Mode, clear, RX_Data_Ready, RX_Error, TX_Error} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b want all zero", {TX_Packet, Active_EP, Toggle, RX_Transfer_Active, TX_Transfer_Active, D_Mode, clear, RX_Data_Ready, RX_Error, TX_Error}); end
    @(negedge clk);
    n_rst = 1'b1;
    model_tog = '0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_out_fresh_and_dup();
    test_in_paths();
    test_timeout();
    test_corrupt();
    test_random(60);
    test_reset_mid_transaction();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
